// File: rtl/enet_phy_poller.sv
// Wishbone master that polls DP83848 BMSR/PHYSTS through the MDIO controller and decodes link status.
// Define ENET_POLL_INIT_EN to issue a single BMCR_INIT write to BMCR_ADDR after reset, before polling.
module enet_phy_poller #(
  parameter int                   TIMERBITS     = 24,
  parameter logic [TIMERBITS-1:0] POLL_INTERVAL = 24'd10000000,
  parameter logic [11:0]          TIMEOUT       = 12'd2047,
  parameter logic [4:0]           BMSR_ADDR     = 5'h01,
  parameter logic [4:0]           PHYSTS_ADDR   = 5'h10,
  parameter logic [4:0]           BMCR_ADDR     = 5'h00,
  parameter logic [15:0]          BMCR_INIT     = 16'h1200
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic        i_poll_now,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [4:0]  o_wb_addr,
  output logic [15:0] o_wb_data,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic [31:0] i_wb_data,
  output logic [15:0] o_bmsr,
  output logic [15:0] o_physts,
  output logic        o_link_up,
  output logic        o_speed100,
  output logic        o_full_duplex,
  output logic        o_link_chg,
  output logic        o_err
);

  // G* states hold cyc low for one cycle after each ack
  typedef enum logic [2:0] {
    S_IDLE, S_RBMSR, S_GBMSR, S_RSTS, S_GSTS, S_UPDATE
`ifdef ENET_POLL_INIT_EN
    , S_INIT, S_WBMCR
`endif
  } state_t;

`ifdef ENET_POLL_INIT_EN
  localparam state_t RESET_STATE = S_INIT;
`else
  localparam state_t RESET_STATE = S_IDLE;
`endif

  function automatic logic is_txn(input state_t s);
    is_txn = (s == S_RBMSR) || (s == S_RSTS)
`ifdef ENET_POLL_INIT_EN
      || (s == S_WBMCR)
`endif
      ;
  endfunction

  state_t                 state, state_n;
  logic [TIMERBITS-1:0]   timer;
  logic                   pending;
  logic                   stb_pend;
  logic [11:0]            tcnt;
  logic [15:0]            shadow_bmsr, shadow_sts;
  logic                   status_vld;
  logic                   in_txn, txn_enter, start, tmo, new_link;

  assign in_txn    = is_txn(state);
  assign txn_enter = is_txn(state_n) & ~in_txn;
  assign start     = (state == S_IDLE) & ((i_en & (timer == '0)) | pending);
  // an ack in the timeout cycle wins
  assign tmo       = in_txn & ~i_wb_ack & (tcnt == TIMEOUT - 12'd1);
  assign new_link  = shadow_bmsr[2] & shadow_sts[0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= RESET_STATE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (start) state_n = S_RBMSR;
      S_RBMSR:  if (i_wb_ack) state_n = S_GBMSR; else if (tmo) state_n = S_IDLE;
      S_GBMSR:  state_n = S_RSTS;
      S_RSTS:   if (i_wb_ack) state_n = S_GSTS; else if (tmo) state_n = S_IDLE;
      S_GSTS:   state_n = S_UPDATE;
      S_UPDATE: state_n = S_IDLE;
`ifdef ENET_POLL_INIT_EN
      S_INIT:   state_n = S_WBMCR;
      S_WBMCR:  if (i_wb_ack || tmo) state_n = S_IDLE;
`endif
      default:  state_n = S_IDLE;
    endcase
  end

  always_comb begin
    o_wb_cyc  = in_txn;
    o_wb_stb  = in_txn & stb_pend;
    o_wb_addr = '0;
`ifdef ENET_POLL_INIT_EN
    o_wb_we   = 1'b0;
    o_wb_data = '0;
`endif
    case (state)
      S_RBMSR: o_wb_addr = BMSR_ADDR;
      S_RSTS:  o_wb_addr = PHYSTS_ADDR;
`ifdef ENET_POLL_INIT_EN
      S_WBMCR: begin
        o_wb_addr = BMCR_ADDR;
        o_wb_we   = 1'b1;
        o_wb_data = BMCR_INIT;
      end
`endif
      default: ;
    endcase
  end

`ifdef ENET_POLL_INIT_EN
  logic unused_ok;
  assign unused_ok = &{1'b0, i_wb_data[31:16]};
`else
  logic unused_ok;
  assign o_wb_we   = 1'b0;
  assign o_wb_data = '0;
  assign unused_ok = &{1'b0, i_wb_data[31:16], BMCR_ADDR, BMCR_INIT};
`endif

  // timer runs in every state so poll starts stay exactly POLL_INTERVAL apart
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      timer    <= '0;
      pending  <= 1'b0;
      stb_pend <= 1'b0;
      tcnt     <= '0;
      o_err    <= 1'b0;
    end else begin
      if (start)             timer <= POLL_INTERVAL - TIMERBITS'(1);
      else if (timer != '0)  timer <= timer - TIMERBITS'(1);
      pending <= (pending & ~start) | i_poll_now;
      if (txn_enter) begin
        stb_pend <= 1'b1;
        tcnt     <= '0;
      end else begin
        if (o_wb_stb && !i_wb_stall) stb_pend <= 1'b0;
        if (in_txn) tcnt <= tcnt + 12'd1;
      end
      o_err <= tmo;
    end
  end

  always_ff @(posedge i_clk) begin
    if (state == S_RBMSR && i_wb_ack) shadow_bmsr <= i_wb_data[15:0];
    if (state == S_RSTS  && i_wb_ack) shadow_sts  <= i_wb_data[15:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_bmsr     <= '0;
      o_physts   <= '0;
      status_vld <= 1'b0;
      o_link_chg <= 1'b0;
    end else begin
      o_link_chg <= (state == S_UPDATE) && (new_link != o_link_up);
      if (state == S_UPDATE) begin
        o_bmsr     <= shadow_bmsr;
        o_physts   <= shadow_sts;
        status_vld <= 1'b1;
      end
    end
  end

  // decode is gated until the first poll so every output is 0 out of reset
  assign o_link_up     = status_vld & o_bmsr[2] & o_physts[0];
  assign o_speed100    = status_vld & ~o_physts[1];
  assign o_full_duplex = status_vld & o_physts[2];

endmodule

// File: tb/tb_enet_phy_poller.sv
// Directed bench for enet_phy_poller with a behavioural MDIO-controller wishbone slave.
module tb_enet_phy_poller;
  localparam int PI = 300;
  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rst_n, en, poll_now;
  logic        cyc, stb, we;
  logic [4:0]  addr;
  logic [15:0] wdata;
  logic        ack, stall;
  logic [31:0] rdata;
  logic [15:0] bmsr, physts;
  logic        link_up, speed100, full_duplex, link_chg, err;

  always #5 clk = ~clk;

  enet_phy_poller #(
    .TIMERBITS(24), .POLL_INTERVAL(24'(PI)), .TIMEOUT(12'(TO))
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_poll_now(poll_now),
    .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_we(we), .o_wb_addr(addr), .o_wb_data(wdata),
    .i_wb_ack(ack), .i_wb_stall(stall), .i_wb_data(rdata),
    .o_bmsr(bmsr), .o_physts(physts), .o_link_up(link_up), .o_speed100(speed100),
    .o_full_duplex(full_duplex), .o_link_chg(link_chg), .o_err(err)
  );

  int total = 0;
  int bad   = 0;

  // slave configuration
  logic [15:0] cfg_bmsr = 16'h0000;
  logic [15:0] cfg_sts  = 16'h0000;
  int          cfg_dly  = 4;
  int          cfg_stall = 0;
  logic        cfg_noack = 1'b0;

  // monitor state and logs
  int          ncnt = 0;
  logic        active = 1'b0;
  int          age = 0, cyc_len = 0, stb_len = 0, stall_now = 0;
  int          t_start[$];
  logic [4:0]  t_addr[$];
  logic        t_we[$];
  logic [15:0] t_wdata[$];
  int          t_cyclen[$];
  int          t_stblen[$];
  int          chg_cnt = 0, chg_cycle = 0, err_cnt = 0, err_cycle = 0, upd_cycle = 0;
  logic [15:0] bmsr_prev = 16'h0000;
  int          poll0_start = 0;

  initial begin
    ack = 1'b0; stall = 1'b0; rdata = 32'h0;
    forever begin
      @(negedge clk);
      ncnt++;
      if (!cyc && active) begin
        t_cyclen.push_back(cyc_len);
        t_stblen.push_back(stb_len);
        active = 1'b0;
      end
      if (cyc && !active) begin
        active = 1'b1; age = 0; cyc_len = 0; stb_len = 0;
        stall_now = cfg_stall; cfg_stall = 0;
        t_start.push_back(ncnt); t_addr.push_back(addr);
        t_we.push_back(we); t_wdata.push_back(wdata);
      end else if (cyc) begin
        age++;
      end
      if (cyc) cyc_len++;
      if (stb) stb_len++;
      if (link_chg) begin chg_cnt++; chg_cycle = ncnt; end
      if (err) begin err_cnt++; err_cycle = ncnt; end
      if (bmsr != bmsr_prev) upd_cycle = ncnt;
      bmsr_prev = bmsr;
      ack = 1'b0; stall = 1'b0; rdata = 32'hDEAD_BEEF;
      if (cyc) begin
        stall = (age < stall_now);
        if (!cfg_noack && age == cfg_dly) begin
          ack   = 1'b1;
          rdata = {16'hFFFF, (addr == 5'h01) ? cfg_bmsr : cfg_sts};
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    t_start.delete(); t_addr.delete(); t_we.delete(); t_wdata.delete();
    t_cyclen.delete(); t_stblen.delete();
    chg_cnt = 0; err_cnt = 0;
  endtask

  task automatic wait_txn(input int n, input int budget);
    for (int i = 0; i < budget && t_start.size() < n; i++) step();
  endtask

  task automatic pulse_poll();
    poll_now = 1'b1;
    step();
    poll_now = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; poll_now = 1'b0;
    cfg_dly = 4; cfg_noack = 1'b0;
    repeat (3) step();
    total++; if ({cyc, stb, we} !== 3'b000) begin bad++; $display("FAIL reset_wb: got %b want 000", {cyc, stb, we}); end
    total++; if ({addr, wdata} !== 21'h0) begin bad++; $display("FAIL reset_addr_data: got %h want 0", {addr, wdata}); end
    total++; if ({bmsr, physts} !== 32'h0) begin bad++; $display("FAIL reset_status: got %h want 0", {bmsr, physts}); end
    total++; if ({link_up, speed100, full_duplex, link_chg, err} !== 5'b0) begin
      bad++; $display("FAIL reset_decoded: got %b want 00000", {link_up, speed100, full_duplex, link_chg, err});
    end
    clear_logs();
    rst_n = 1'b1;
`ifdef ENET_POLL_INIT_EN
    wait_txn(1, 20);
    repeat (10) step();
    total++; if (t_start.size() !== 1) begin bad++; $display("FAIL init_count: got %0d want 1", t_start.size()); end
    total++; if (t_we[0] !== 1'b1) begin bad++; $display("FAIL init_we: got %b want 1", t_we[0]); end
    total++; if (t_addr[0] !== 5'h00) begin bad++; $display("FAIL init_addr: got %h want 00", t_addr[0]); end
    total++; if (t_wdata[0] !== 16'h1200) begin bad++; $display("FAIL init_data: got %h want 1200", t_wdata[0]); end
    total++; if (cyc !== 1'b0) begin bad++; $display("FAIL init_done_cyc: got %b want 0", cyc); end
`else
    repeat (20) step();
    total++; if (t_start.size() !== 0) begin bad++; $display("FAIL idle_no_poll: got %0d want 0", t_start.size()); end
`endif
  endtask

  task automatic test_first_poll();
    clear_logs();
    cfg_bmsr = 16'h786D; cfg_sts = 16'h0015; cfg_dly = 4;
    en = 1'b1;
    wait_txn(2, 40);
    repeat (12) step();
    poll0_start = t_start[0];
    total++; if (t_start.size() !== 2) begin bad++; $display("FAIL fp_count: got %0d want 2", t_start.size()); end
    total++; if (t_addr[0] !== 5'h01 || t_addr[1] !== 5'h10) begin
      bad++; $display("FAIL fp_addr: got %h,%h want 01,10", t_addr[0], t_addr[1]);
    end
    total++; if (t_we[0] !== 1'b0 || t_we[1] !== 1'b0) begin bad++; $display("FAIL fp_we: got %b%b want 00", t_we[0], t_we[1]); end
    total++; if (t_start[1] - t_start[0] !== 6) begin bad++; $display("FAIL fp_gap: got %0d want 6", t_start[1] - t_start[0]); end
    total++; if (upd_cycle - t_start[0] !== 13) begin bad++; $display("FAIL fp_latency: got %0d want 13", upd_cycle - t_start[0]); end
    total++; if (bmsr !== 16'h786D || physts !== 16'h0015) begin
      bad++; $display("FAIL fp_regs: got %h %h want 786d 0015", bmsr, physts);
    end
    total++; if ({link_up, speed100, full_duplex} !== 3'b111) begin
      bad++; $display("FAIL fp_decode: got %b want 111", {link_up, speed100, full_duplex});
    end
    total++; if (chg_cnt !== 1) begin bad++; $display("FAIL fp_chg_count: got %0d want 1", chg_cnt); end
    total++; if (chg_cycle - t_start[0] !== 13) begin bad++; $display("FAIL fp_chg_time: got %0d want 13", chg_cycle - t_start[0]); end
    total++; if (err_cnt !== 0) begin bad++; $display("FAIL fp_err: got %0d want 0", err_cnt); end
  endtask

  task automatic test_link_drop();
    clear_logs();
    cfg_bmsr = 16'h7869;
    wait_txn(2, PI + 20);
    repeat (12) step();
    en = 1'b0;
    total++; if (t_start.size() !== 2) begin bad++; $display("FAIL ld_count: got %0d want 2", t_start.size()); end
    total++; if (t_start[0] - poll0_start !== PI) begin
      bad++; $display("FAIL ld_interval: got %0d want %0d", t_start[0] - poll0_start, PI);
    end
    total++; if (bmsr !== 16'h7869) begin bad++; $display("FAIL ld_bmsr: got %h want 7869", bmsr); end
    total++; if (link_up !== 1'b0) begin bad++; $display("FAIL ld_link: got %b want 0", link_up); end
    total++; if (chg_cnt !== 1) begin bad++; $display("FAIL ld_chg_count: got %0d want 1", chg_cnt); end
  endtask

  task automatic test_stall();
    clear_logs();
    cfg_bmsr = 16'h786D; cfg_sts = 16'h0015; cfg_dly = 14; cfg_stall = 10;
    pulse_poll();
    wait_txn(2, 60);
    repeat (20) step();
    total++; if (t_stblen[0] !== 11) begin bad++; $display("FAIL st_stb_len: got %0d want 11", t_stblen[0]); end
    total++; if (t_cyclen[0] !== 15) begin bad++; $display("FAIL st_cyc_len: got %0d want 15", t_cyclen[0]); end
    total++; if (t_stblen[1] !== 1) begin bad++; $display("FAIL st_stb_len2: got %0d want 1", t_stblen[1]); end
    total++; if (err_cnt !== 0) begin bad++; $display("FAIL st_err: got %0d want 0", err_cnt); end
    total++; if (link_up !== 1'b1 || chg_cnt !== 1) begin
      bad++; $display("FAIL st_link: got link=%b chg=%0d want link=1 chg=1", link_up, chg_cnt);
    end
    cfg_dly = 4;
  endtask

  task automatic test_timeout();
    clear_logs();
    cfg_noack = 1'b1;
    pulse_poll();
    repeat (TO + 15) step();
    cfg_noack = 1'b0;
    total++; if (t_start.size() !== 1) begin bad++; $display("FAIL to_count: got %0d want 1", t_start.size()); end
    total++; if (t_cyclen[0] !== TO) begin bad++; $display("FAIL to_cyc_len: got %0d want %0d", t_cyclen[0], TO); end
    total++; if (err_cnt !== 1) begin bad++; $display("FAIL to_err_count: got %0d want 1", err_cnt); end
    total++; if (err_cycle - t_start[0] !== TO) begin bad++; $display("FAIL to_err_time: got %0d want %0d", err_cycle - t_start[0], TO); end
    total++; if (bmsr !== 16'h786D || physts !== 16'h0015 || link_up !== 1'b1) begin
      bad++; $display("FAIL to_hold: got %h %h %b want 786d 0015 1", bmsr, physts, link_up);
    end
  endtask

  task automatic test_ack_at_timeout();
    clear_logs();
    cfg_bmsr = 16'h782D; cfg_sts = 16'h0011; cfg_dly = TO - 1;
    pulse_poll();
    repeat (2 * TO + 20) step();
    cfg_dly = 4;
    total++; if (err_cnt !== 0) begin bad++; $display("FAIL at_err: got %0d want 0", err_cnt); end
    total++; if (t_start.size() !== 2) begin bad++; $display("FAIL at_count: got %0d want 2", t_start.size()); end
    total++; if (bmsr !== 16'h782D || physts !== 16'h0011) begin
      bad++; $display("FAIL at_regs: got %h %h want 782d 0011", bmsr, physts);
    end
    total++; if ({link_up, speed100, full_duplex} !== 3'b110) begin
      bad++; $display("FAIL at_decode: got %b want 110", {link_up, speed100, full_duplex});
    end
    total++; if (chg_cnt !== 0) begin bad++; $display("FAIL at_chg: got %0d want 0", chg_cnt); end
  endtask

  task automatic test_poll_now_rsts();
    clear_logs();
    cfg_bmsr = 16'h786D; cfg_sts = 16'h0015;
    pulse_poll();
    for (int i = 0; i < 30 && !(cyc && addr == 5'h10); i++) step();
    pulse_poll();
    repeat (60) step();
    total++; if (t_start.size() !== 4) begin bad++; $display("FAIL pn_count: got %0d want 4", t_start.size()); end
    total++; if (t_start[2] - t_start[0] !== 14) begin bad++; $display("FAIL pn_restart: got %0d want 14", t_start[2] - t_start[0]); end
    total++; if (t_addr[2] !== 5'h01 || t_addr[3] !== 5'h10) begin
      bad++; $display("FAIL pn_addr: got %h,%h want 01,10", t_addr[2], t_addr[3]);
    end
    total++; if (full_duplex !== 1'b1) begin bad++; $display("FAIL pn_duplex: got %b want 1", full_duplex); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; poll_now = 1'b0;
    test_reset();
    test_first_poll();
    test_link_drop();
    test_stall();
    test_timeout();
    test_ack_at_timeout();
    test_poll_now_rsts();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
